// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream while holding the CPU.
// The stream is a 16-bit big-endian word count followed by the program bytes.
// Bytes are packed big-endian into 32-bit words, one write per word, at
// consecutive word-aligned addresses starting at BASE_ADDR.
//
// Ports:
//   CLK, RSTn          clock, asynchronous active-low reset
//   start              begin a load (honoured only when idle)
//   byte_valid/_data   incoming stream byte
//   byte_ready         loader accepts a byte this cycle
//   mem_we/addr/wdata  instruction-memory write port (addr/wdata valid with mem_we)
//   cpu_hold, busy     high for the whole load, including the DONE cycle
//   done               one-cycle completion pulse
module imem_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    count, count_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [WORD_W-1:0]   word, word_nxt;
  logic [WORD_W-1:0]   mem_addr_nxt, mem_wdata_nxt;
  logic                byte_ready_nxt, mem_we_nxt, busy_nxt, done_nxt;
  logic                xfer_c;

  assign xfer_c = byte_valid & byte_ready;

  // State and datapath registers; outputs are registered from next-state decode.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= S_IDLE;
      count      <= '0;
      addr       <= '0;
      idx        <= '0;
      word       <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      addr       <= addr_nxt;
      idx        <= idx_nxt;
      word       <= word_nxt;
      byte_ready <= byte_ready_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      cpu_hold   <= busy_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    addr_nxt      = addr;
    idx_nxt       = idx;
    word_nxt      = word;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_HDR_HI;
          addr_nxt  = ADDR_W'(BASE_ADDR);
          idx_nxt   = '0;
        end
      end
      S_HDR_HI: begin
        if (xfer_c) begin
          count_nxt = {byte_data, count[7:0]};
          state_nxt = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (xfer_c) begin
          count_nxt = {count[15:8], byte_data};
          state_nxt = ((count[15:8] == 8'd0) && (byte_data == 8'd0)) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (xfer_c) begin
          // Shift-in packing puts the first byte of the word in [31:24].
          word_nxt = {word[23:0], byte_data};
          idx_nxt  = idx + IDX_W'(1);
          if (idx == IDX_W'(3)) begin
            state_nxt     = S_WRITE;
            idx_nxt       = '0;
            mem_addr_nxt  = WORD_W'(addr);
            mem_wdata_nxt = {word[23:0], byte_data};
          end
        end
      end
      S_WRITE: begin
        addr_nxt  = addr + ADDR_W'(4);
        count_nxt = count - CNT_W'(1);
        state_nxt = (count == CNT_W'(1)) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    byte_ready_nxt = (state_nxt == S_HDR_HI) || (state_nxt == S_HDR_LO) ||
                     (state_nxt == S_DATA);
    mem_we_nxt     = (state_nxt == S_WRITE);
    busy_nxt       = (state_nxt != S_IDLE);
    done_nxt       = (state_nxt == S_DONE);
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// Two instances share one stimulus stream: the default configuration and a
// 16-byte span starting at 0xC, so every load also exercises address wrap.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;

  logic        br_a, we_a, hold_a, busy_a, done_a;
  logic [31:0] addr_a, wd_a;
  logic        br_b, we_b, hold_b, busy_b, done_b;
  logic [31:0] addr_b, wd_b;

  always #5 CLK = ~CLK;

  imem_loader dut_a (
    .CLK(CLK), .RSTn(RSTn), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(br_a), .mem_we(we_a),
    .mem_addr(addr_a), .mem_wdata(wd_a), .cpu_hold(hold_a),
    .busy(busy_a), .done(done_a)
  );

  imem_loader #(.ADDR_W(4), .BASE_ADDR(12)) dut_b (
    .CLK(CLK), .RSTn(RSTn), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(br_b), .mem_we(we_b),
    .mem_addr(addr_b), .mem_wdata(wd_b), .cpu_hold(hold_b),
    .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Write log filled by the monitor.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
  } wr_t;
  wr_t wlog[$];

  // Reference model: byte counting over one load, no state encoding.
  bit          m_loading, m_we, m_done, m_busy;
  bit          n_we, n_done, n_busy, m_rdy;
  int          m_nb, m_words;
  logic [15:0] m_hdr;
  logic [31:0] m_cur, m_wdata, n_wdata;

  always @(negedge CLK) begin
    if (!RSTn) begin
      check("rst_flags_a", 32'({br_a, we_a, hold_a, busy_a, done_a}), 32'd0);
      check("rst_flags_b", 32'({br_b, we_b, hold_b, busy_b, done_b}), 32'd0);
      check("rst_addr_a", addr_a, 32'd0);
      check("rst_wdata_a", wd_a, 32'd0);
      m_loading = 0; m_we = 0; m_done = 0; m_busy = 0;
      m_nb = 0; m_words = 0; m_hdr = '0; m_cur = '0; m_wdata = '0;
    end else begin
      m_rdy = m_loading && !m_we;
      check("ready_a", 32'(br_a), 32'(m_rdy));
      check("ready_b", 32'(br_b), 32'(m_rdy));
      check("we_a", 32'(we_a), 32'(m_we));
      check("we_b", 32'(we_b), 32'(m_we));
      check("busy_a", 32'({busy_a, hold_a}), 32'({m_busy, m_busy}));
      check("busy_b", 32'({busy_b, hold_b}), 32'({m_busy, m_busy}));
      check("done_a", 32'(done_a), 32'(m_done));
      check("done_b", 32'(done_b), 32'(m_done));
      if (m_we) begin
        check("addr_a", addr_a, 32'((m_words * 4) % 1024));
        check("addr_b", addr_b, 32'((12 + m_words * 4) % 16));
        check("wdata_a", wd_a, m_wdata);
        check("wdata_b", wd_b, m_wdata);
      end
      if (we_a) wlog.push_back('{a: addr_a, b: addr_b, d: wd_a});

      n_we = 0; n_done = 0; n_wdata = m_wdata;
      n_busy = m_done ? 1'b0 : m_busy;
      if (!m_busy && start) begin
        n_busy = 1; m_loading = 1; m_nb = 0; m_words = 0;
      end
      if (byte_valid && m_rdy) begin
        m_nb++;
        m_cur = {m_cur[23:0], byte_data};
        if (m_nb == 2) begin
          m_hdr = m_cur[15:0];
          if (m_hdr == 16'd0) begin n_done = 1; m_loading = 0; end
        end else if (m_nb > 2 && (m_nb - 2) % 4 == 0) begin
          n_we = 1; n_wdata = m_cur;
        end
      end
      if (m_we) begin
        m_words++;
        if (m_words == int'(m_hdr)) begin n_done = 1; m_loading = 0; end
      end
      m_we = n_we; m_done = n_done; m_busy = n_busy; m_wdata = n_wdata;
    end
  end

  // Stimulus helpers; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit poke);
    bit r, ok;
    ok = 0;
    byte_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      byte_data = 8'($urandom);
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    start      = poke;
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK);
      r = br_a;
      tick();
      start = 1'b0;
      if (r) begin ok = 1; break; end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge CLK);
      if (!busy_a) begin ok = 1; break; end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Image to load and the gap policy: 0 full rate, 1 random, 2 fixed throttle.
  logic [31:0] img[$];
  int          pat_gaps[6] = '{0, 2, 1, 0, 0, 2};

  function automatic int pick_gap(input int mode, input int k);
    if (mode == 0) return 0;
    if (mode == 1) return ($urandom % 3 == 0) ? int'($urandom_range(1, 4)) : 0;
    return pat_gaps[k % 6];
  endfunction

  task automatic run_load(input int mode, input bit pokes);
    int base, n, k;
    logic [31:0] w;
    base = wlog.size();
    n = img.size();
    k = 0;
    pulse_start();
    send(8'(n >> 8), pick_gap(mode, k++), 1'b0);
    send(8'(n), pick_gap(mode, k++), pokes && ($urandom % 2 == 0));
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int j = 3; j >= 0; j--)
        send(w[j*8 +: 8], pick_gap(mode, k++), pokes && ($urandom % 5 == 0));
    end
    byte_valid = 1'b0;
    wait_idle();
    check("write_count", 32'(wlog.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < wlog.size(); i++) begin
      check("log_data", wlog[base + i].d, img[i]);
      check("log_addr_a", wlog[base + i].a, 32'((4 * i) % 1024));
      check("log_addr_b", wlog[base + i].b, 32'((12 + 4 * i) % 16));
    end
  endtask

  initial begin
    int base;
    RSTn = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;
    repeat (2) tick();

    // Basic two-word load at full byte rate.
    base = wlog.size();
    img = '{32'h2008_0005, 32'h8C09_0004};
    run_load(0, 1'b0);
    if (wlog.size() >= base + 2) begin
      check("basic_a0", wlog[base].a, 32'h000);
      check("basic_d0", wlog[base].d, 32'h2008_0005);
      check("basic_a1", wlog[base + 1].a, 32'h004);
      check("basic_d1", wlog[base + 1].d, 32'h8C09_0004);
      check("wrap_b0", wlog[base].b, 32'h00C);
      check("wrap_b1", wlog[base + 1].b, 32'h000);
    end

    // Zero-length image.
    img.delete();
    run_load(0, 1'b0);

    // Single word with a throttled source.
    img = '{32'hDEAD_BEEF};
    run_load(2, 1'b0);

    // Randomized images, gaps and stray start pulses.
    for (int t = 0; t < 8; t++) begin
      img.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) img.push_back($urandom);
      run_load(t % 3, 1'b1);
    end

    // Reset after two data bytes of the first word.
    base = wlog.size();
    pulse_start();
    send(8'h00, 0, 1'b0);
    send(8'h01, 0, 1'b0);
    send(8'hAB, 0, 1'b0);
    send(8'hCD, 0, 1'b0);
    byte_valid = 1'b0;
    RSTn = 1'b0;
    #1;
    check("midrst_flags", 32'({br_a, we_a, hold_a, busy_a, done_a}), 32'd0);
    check("midrst_addr", addr_a, 32'd0);
    check("midrst_wdata", wd_a, 32'd0);
    repeat (2) tick();
    RSTn = 1'b1;
    repeat (2) tick();
    check("midrst_nowrite", 32'(wlog.size() - base), 32'd0);
    img = '{32'h1234_5678};
    run_load(1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
